// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver for the Master_Control command link.
// Bit timing is recovered by counting clk cycles from the start-bit edge; each
// bit is sampled at its nominal centre.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_in       in   serial line (already synchronized), idle high
//   data_out    out  [7:0] last received byte, held between frames
//   data_valid  out  one-cycle strobe, good frame loaded into data_out
//   frame_err   out  one-cycle strobe, stop bit sampled low (data_out still loaded)
//   busy        out  high whenever the receiver is not idle
module serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_in) begin
                    // The detecting edge is cycle 0, so the next START cycle is count 1.
                    state_d = S_START;
                    cnt_d   = CNT_W'(1);
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // High at mid-start means the low pulse was a glitch.
                    state_d = rx_in ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rx_in;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    data_d = shift_q;
                    // Leave at mid-stop so a start edge right after the stop bit is caught.
                    if (rx_in) begin
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // Wait out a held-low line so it is not seen as repeated start bits.
                if (rx_in) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx at 16 clocks per bit (half-bit = 8).
// Each step drives one line value, lets one rising edge sample it, then
// observes the outputs at the following falling edge. The observation after
// step t (t = line cycle index from the start edge) is the output during cycle t+1.
module tb_serial_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks;
    int errors;
    int cyc;

    // Observations recorded by send_frame for the calling test to judge.
    int         rec_nvalid;
    int         rec_nerr;
    int         rec_both;
    int         rec_valid_t;
    int         rec_err_t;
    int         rec_valid_cyc;
    logic [7:0] rec_data;
    logic       rec_busy1;
    logic       rec_busy_at_valid;
    int         rec_busy_low;

    serial_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic b);
        rx_in = b;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // Line level at cycle t of a 10-bit frame: start, 8 data LSB first, stop.
    function automatic logic line_bit(input logic [7:0] b, input logic stop, input int t);
        logic [7:0] v;
        v = b;
        if (t < 16)       return 1'b0;
        else if (t < 144) return v[3'((t - 16) / 16)];
        else              return stop;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rec_nvalid = 0; rec_nerr = 0; rec_both = 0;
        rec_valid_t = -1; rec_err_t = -1; rec_valid_cyc = -1;
        rec_data = 8'hxx; rec_busy1 = 1'b0; rec_busy_at_valid = 1'bx; rec_busy_low = 0;
        for (int t = 0; t < 160; t++) begin
            step(line_bit(b, stop, t));
            if (t == 0) rec_busy1 = busy;
            if (t < 152 && busy !== 1'b1) rec_busy_low++;
            if (data_valid && frame_err) rec_both++;
            if (data_valid === 1'b1) begin
                rec_nvalid++; rec_valid_t = t; rec_valid_cyc = cyc;
                rec_data = data_out; rec_busy_at_valid = busy;
            end
            if (frame_err === 1'b1) begin
                rec_nerr++; rec_err_t = t; rec_data = data_out;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single;
        idle(5);
        send_frame(8'hA5, 1'b1);
        checks++; if (rec_busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_cycle1: got %b want 1", rec_busy1); end
        checks++; if (rec_busy_low != 0) begin errors++; $display("FAIL single_busy_during_frame: low cycles %0d want 0", rec_busy_low); end
        checks++; if (rec_nvalid != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", rec_nvalid); end
        checks++; if (rec_valid_t + 1 != 153) begin errors++; $display("FAIL single_valid_cycle: got %0d want 153", rec_valid_t + 1); end
        checks++; if (rec_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rec_data); end
        checks++; if (rec_nerr != 0) begin errors++; $display("FAIL single_frame_err: got %0d pulses want 0", rec_nerr); end
        checks++; if (rec_busy_at_valid !== 1'b0) begin errors++; $display("FAIL single_busy_at_valid: got %b want 0", rec_busy_at_valid); end
        idle(10);
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h want a5", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int bad_busy, strobes;
        bad_busy = 0; strobes = 0;
        for (int t = 0; t < 21; t++) begin
            step((t < 4) ? 1'b0 : 1'b1);
            checks++;
            if (busy !== ((t <= 7) ? 1'b1 : 1'b0)) begin
                errors++; bad_busy++;
                $display("FAIL glitch_busy cycle %0d: got %b want %b", t + 1, busy, (t <= 7) ? 1'b1 : 1'b0);
            end
            if (data_valid !== 1'b0 || frame_err !== 1'b0) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobe cycles want 0", strobes); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data_out: got %h want a5", data_out); end
    endtask

    task automatic test_frame_err;
        int strobes;
        strobes = 0;
        send_frame(8'h3C, 1'b0);
        checks++; if (rec_nerr != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", rec_nerr); end
        checks++; if (rec_err_t + 1 != 153) begin errors++; $display("FAIL ferr_cycle: got %0d want 153", rec_err_t + 1); end
        checks++; if (rec_nvalid != 0) begin errors++; $display("FAIL ferr_valid: got %0d pulses want 0", rec_nvalid); end
        checks++; if (rec_data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", rec_data); end
        // Line held low for 40 more cycles (160..199), then released high.
        for (int t = 160; t < 210; t++) begin
            step((t < 200) ? 1'b0 : 1'b1);
            checks++;
            if (busy !== ((t < 200) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ferr_break_busy cycle %0d: got %b want %b", t + 1, busy, (t < 200) ? 1'b1 : 1'b0);
            end
            if (data_valid !== 1'b0 || frame_err !== 1'b0) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL ferr_break_strobe: got %0d want 0", strobes); end
        send_frame(8'h81, 1'b1);
        checks++; if (rec_nvalid != 1) begin errors++; $display("FAIL ferr_next_valid: got %0d want 1", rec_nvalid); end
        checks++; if (rec_data !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", rec_data); end
        checks++; if (rec_nerr != 0) begin errors++; $display("FAIL ferr_next_err: got %0d want 0", rec_nerr); end
    endtask

    task automatic test_back_to_back;
        int v1, n1;
        logic [7:0] d1;
        idle(5);
        send_frame(8'h00, 1'b1);
        v1 = rec_valid_cyc; n1 = rec_nvalid; d1 = rec_data;
        send_frame(8'hFF, 1'b1);
        checks++; if (n1 != 1) begin errors++; $display("FAIL b2b_first_count: got %0d want 1", n1); end
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h want 00", d1); end
        checks++; if (rec_nvalid != 1) begin errors++; $display("FAIL b2b_second_count: got %0d want 1", rec_nvalid); end
        checks++; if (rec_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h want ff", rec_data); end
        checks++; if (rec_valid_cyc - v1 != 160) begin errors++; $display("FAIL b2b_spacing: got %0d want 160", rec_valid_cyc - v1); end
        checks++; if (rec_both != 0) begin errors++; $display("FAIL b2b_both_strobes: got %0d want 0", rec_both); end
    endtask

    task automatic test_reset_mid;
        int strobes, busy_hi;
        strobes = 0; busy_hi = 0;
        idle(5);
        for (int t = 0; t < 50; t++) step(line_bit(8'h77, 1'b1, t));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        step(line_bit(8'h77, 1'b1, 50));
        rst = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rmid_data_out: got %h want 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_data_valid: got %b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_frame_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        for (int i = 0; i < 200; i++) begin
            step(1'b1);
            if (data_valid !== 1'b0 || frame_err !== 1'b0) strobes++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL rmid_strobe: got %0d want 0", strobes); end
        checks++; if (busy_hi != 0) begin errors++; $display("FAIL rmid_idle_busy: got %0d busy cycles want 0", busy_hi); end
        send_frame(8'h5A, 1'b1);
        checks++; if (rec_nvalid != 1) begin errors++; $display("FAIL rmid_next_valid: got %0d want 1", rec_nvalid); end
        checks++; if (rec_valid_t + 1 != 153) begin errors++; $display("FAIL rmid_next_cycle: got %0d want 153", rec_valid_t + 1); end
        checks++; if (rec_data !== 8'h5A) begin errors++; $display("FAIL rmid_next_data: got %h want 5a", rec_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        rx_in  = 1'b1;
        test_reset;
        test_single;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
